operand_feeder: RTL
===================

OPERAND_FEEDER -- requirements
Module: operand_feeder

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning operand width in bits.
REQ-002 The block SHALL have parameter FRAME, default 8, meaning cycles per bit-serial add frame; FRAME SHALL equal W.
REQ-003 The block SHALL have parameter DEPTH, default 2, meaning input buffer entries (DEPTH >= 1).
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  upstream offers an operand set.
REQ-007 in_ready  out  1  block accepts the offered set this cycle.
REQ-008 in_a, in_b, in_c, in_d  in  W each  offered operands.
REQ-009 a, b, c, d  out  W each  registered operands to the bit-serial four-operand adder.
REQ-010 frame_start  out  1  high during phase 0 of every frame.
REQ-011 op_valid  out  1  high for the whole frame when a..d carry a real operand set.
REQ-012 level  out  clog2(DEPTH+1)  current buffer occupancy.

Function
REQ-013 The block SHALL keep a phase counter that counts 0..FRAME-1 and wraps to 0; frame_start = (phase == 0).
REQ-014 Push: on a rising edge with in_valid && in_ready, {in_a,in_b,in_c,in_d} SHALL be written to the FIFO tail.
REQ-015 in_ready SHALL equal (level < DEPTH), combinational from registered state only; there is no full-buffer bypass, so a set is never accepted while full, even in a pop cycle.
REQ-016 Pop: on the rising edge where phase == FRAME-1, if the pre-edge level > 0 the head SHALL load a..d and op_valid <= 1; otherwise a..d <= 0 and op_valid <= 0.
REQ-017 A set pushed on the same edge as a pop decision SHALL NOT be popped on that edge; the pop uses pre-edge occupancy.
REQ-018 A simultaneous push and pop SHALL leave level unchanged and preserve FIFO order.
REQ-019 a..d and op_valid SHALL change only on the phase FRAME-1 -> 0 edge and SHALL stay stable for all FRAME cycles of a frame.
REQ-020 Minimum latency SHALL be as follows: a set accepted on the edge ending phase p (p < FRAME-1) appears on a..d from the next phase 0; a set accepted on the edge ending phase FRAME-1 appears one frame later.
REQ-021 FIFO pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or go below 0.
REQ-022 Sustained throughput SHALL be one operand set per FRAME cycles; backpressure is via in_ready only, and no set is dropped or duplicated.

Reset
REQ-023 While rst = 0, phase = 0, level = 0, FIFO pointers = 0, a..d = 0, op_valid = 0; in_ready = 1 when DEPTH >= 1.
REQ-024 FIFO contents SHALL be discarded on reset; reset mid-frame or mid-handshake SHALL abort without emitting partial sets.
REQ-025 After rst deasserts, the first rising edge SHALL advance phase 0 -> 1, so the first cycle after release is phase 0 and aligns with the adder control ring.

Verification
REQ-026 Reset: rst = 0 for 3 cycles with in_valid = 1 -> a..d = 0, op_valid = 0, level = 0, frame_start = 1 throughout.
REQ-027 Single set: push {1,2,3,4} at phase 2 -> level = 1; at the next phase 0, a..d = 1,2,3,4 and op_valid = 1 for 8 cycles, and level = 0 from then on.
REQ-028 Fill: push 3 sets back-to-back starting at phase 1 -> sets 1 and 2 are accepted and in_ready = 0 on the third; the third is accepted only after the phase 7 pop; output order is set1, set2, set3 in consecutive frames.
REQ-029 Edge push: push {9,9,9,9} exactly at phase 7 with the FIFO empty -> the following frame has op_valid = 0 and a..d = 0; the frame after has a..d = 9 and op_valid = 1.
REQ-030 Idle: no pushes for 3 frames after a valid frame -> op_valid = 0, a..d = 0, and frame_start pulses every 8 cycles.
REQ-031 Mid-frame reset: rst = 0 at phase 4 with level = 2 -> all outputs = 0 and level = 0 immediately; after release, phase restarts at 0 and no stale set is emitted.

Source files
------------

// File: rtl/operand_feeder.sv
// Operand feeder: buffers four-operand sets and presents one set per
// bit-serial frame to the adder, switching outputs only at frame boundaries.
module operand_feeder #(
  parameter int unsigned W     = 8,
  parameter int unsigned FRAME = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_a,
  input  logic [W-1:0]               in_b,
  input  logic [W-1:0]               in_c,
  input  logic [W-1:0]               in_d,
  output logic [W-1:0]               a,
  output logic [W-1:0]               b,
  output logic [W-1:0]               c,
  output logic [W-1:0]               d,
  output logic                       frame_start,
  output logic                       op_valid,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW = 4 * W;

  logic [PW-1:0] phase;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [SW-1:0] mem [DEPTH];
  logic [SW-1:0] head;
  logic          last_phase;
  logic          push;
  logic          pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Pop decisions use pre-edge occupancy, so a same-edge push is never popped.
  assign last_phase  = (phase == PW'(FRAME - 1));
  assign in_ready    = (level < LW'(DEPTH));
  assign push        = in_valid && in_ready;
  assign pop         = last_phase && (level != '0);
  assign frame_start = (phase == '0);
  assign head        = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      op_valid <= 1'b0;
      a        <= '0;
      b        <= '0;
      c        <= '0;
      d        <= '0;
    end else begin
      phase <= last_phase ? '0 : phase + PW'(1);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
      // Adder operands are held for the whole frame and only reload at its end.
      if (last_phase) begin
        op_valid     <= pop;
        {a, b, c, d} <= pop ? head : '0;
      end
    end
  end

  // Storage needs no reset: pointers and level define what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_a, in_b, in_c, in_d};
  end

endmodule
